fwd_ctrl: RTL and testbench
===========================

Name: fwd_ctrl

Overview:
- Control-side partner of the EX forwarding mux: produces the registered 2-bit asel/bsel codes the mux consumes in X, plus kill/valid state.
- Sits between decode and X in the 3-stage pipeline (D, X, WB).
- Keeps a shadow pipeline of in-flight destination registers.
- Handles flush on branch mispredict and whole-pipe stall on memory wait; keeps forwarding performance counters.

Parameters:
REG_AW, 5, register address width
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipe-wide hold (memory not ready)
flush  in  1  kill the instruction currently in D (mispredict resolved in X)
d_valid  in  1  D holds a real instruction
d_rs1  in  REG_AW  D source 1
d_rs2  in  REG_AW  D source 2
d_rd  in  REG_AW  D destination
d_reg_wen  in  1  D writes the register file
d_uses_rs1  in  1  D reads rs1
d_uses_rs2  in  1  D reads rs2
d_a_pc  in  1  ALU operand A is PC
d_b_imm  in  1  ALU operand B is immediate
x_asel  out  2  operand-A select for X
x_bsel  out  2  operand-B select for X
x_valid  out  1  X instruction live (not killed/bubble)
rf_byp1  out  1  D rs1 must take WB write data (same-cycle regfile write)
rf_byp2  out  1  D rs2 must take WB write data
fwd_cnt  out  CNT_W  X instructions retired with any forwarding
kill_cnt  out  CNT_W  instructions killed by flush

Behaviour:
- Select encoding, shared with the mux:
  - bit1 = forward wb_val as the register operand; the branch-compare operand is always forwarded when bit1 = 1.
  - bit0 = ALU operand is PC (asel) or imm (bsel).
  - 00 = reg, 01 = pc/imm, 10 = wb_val, 11 = pc/imm to ALU with wb_val to branch compare.
- State:
  - X record {valid, rd, wen}, WB record {valid, rd, wen}.
  - Registered x_asel, x_bsel, x_valid.
  - Two counters.
- Reset (async, rst_n low): records invalid, rd = 0, wen = 0; x_asel = x_bsel = 00; x_valid = 0; counters = 0. Reset mid-operation clears immediately, with no drain.
- Hazard match in D: hitN = d_uses_rsN & d_rsN != 0 & Xrec.valid & Xrec.wen & Xrec.rd == d_rsN. The instruction currently in X is in WB when D reaches X.
- Normal advance (stall = 0, flush = 0), each rising edge:
  - WB record <= X record.
  - X record <= {d_valid, d_rd, d_reg_wen}.
  - x_asel <= {hit1, d_a_pc}; x_bsel <= {hit2, d_b_imm}; x_valid <= d_valid.
- Latency: one cycle from D inputs to selects.
- flush = 1 (stall = 0):
  - X record valid <= 0, x_valid <= 0, x_asel = x_bsel <= 00.
  - WB record still advances.
  - kill_cnt += 1 if d_valid.
- stall = 1: every register holds, counters included. Stall has priority over flush; flush during a stall is ignored, and the branch unit re-presents it because X is held.
- rf_byp1/2 are combinational: d_uses_rsN & d_rsN != 0 & WBrec.valid & WBrec.wen & WBrec.rd == d_rsN.
- fwd_cnt += 1 on a non-stalled edge where x_valid & (x_asel[1] | x_bsel[1]).
- Counters wrap modulo 2^CNT_W, with no saturation.
- x0 never forwards or bypasses, even with wen = 1.
- Bubbles (d_valid = 0) propagate as invalid records and never match.

Decomposition:
- Shared package (fwd_pkg): select-code constants SEL_REG = 2'b00, SEL_ALT = 2'b01, SEL_WB = 2'b10, SEL_WB_ALT = 2'b11; REG_AW default; pipe record typedef {valid, rd, wen}. The forwarding mux uses the same package.
- Sub-module: fwd_match (one comparator: record + source reg + uses -> hit), instantiated four times (hit1, hit2, rf_byp1, rf_byp2).

Test Plan:
- Reset then idle: after rst_n low, all outputs 0; after release with d_valid = 0 for 3 cycles, x_valid = 0 and selects 00.
- Back-to-back dependency: add x5 then add x6, x5, x1 -> second instruction in X shows x_asel = 10, x_bsel = 00; fwd_cnt = 1 after it leaves X.
- Alt plus forward: producer rd = 7, then consumer rs1 = 7, d_a_pc = 1, rs2 = 7, d_b_imm = 1 -> x_asel = 11, x_bsel = 11.
- Distance-2 and x0: producer rd = 3, one bubble, then consumer rs1 = 3 -> rf_byp1 = 1 in D, x_asel = 00. Producer rd = 0 followed by consumer rs1 = 0 -> no hit.
- Flush: flush = 1 with d_valid = 1 -> next cycle x_valid = 0, selects 00, kill_cnt = 1. A later consumer of the killed rd sees no forward.
- Stall/flush priority and reset: 3-cycle stall with flush = 1 -> outputs and counters frozen, kill_cnt unchanged. Assert rst_n low mid-stall -> outputs 0 before the next edge.

Source files
------------

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared select codes and pipe record for the EX forwarding path
package fwd_pkg;

    localparam int FWD_REG_AW = 5;

    localparam logic [1:0] SEL_REG    = 2'b00;
    localparam logic [1:0] SEL_ALT    = 2'b01;
    localparam logic [1:0] SEL_WB     = 2'b10;
    localparam logic [1:0] SEL_WB_ALT = 2'b11;

    typedef struct packed {
        logic                  valid;
        logic [FWD_REG_AW-1:0] rd;
        logic                  wen;
    } pipe_rec_t;

    // bit1 steers wb_val onto the register operand, bit0 picks pc/imm for the ALU
    function automatic logic [1:0] make_sel(input logic fwd, input logic alt);
        if (fwd) begin
            return alt ? SEL_WB_ALT : SEL_WB;
        end
        return alt ? SEL_ALT : SEL_REG;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - one source-vs-record hazard comparator
module fwd_match #(
    parameter int REG_AW = 5
) (
    input  logic              rec_valid,
    input  logic [REG_AW-1:0] rec_rd,
    input  logic              rec_wen,
    input  logic [REG_AW-1:0] src,
    input  logic              uses,
    output logic              hit
);

    logic w_src_nz;

    // x0 is hardwired, so a write to it is never a real producer
    assign w_src_nz = |src;
    assign hit      = uses & w_src_nz & rec_valid & rec_wen & (rec_rd == src);

endmodule

// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - registered forwarding selects, shadow dest pipe, flush/stall and counters
module fwd_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW = FWD_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_reg_wen,
    input  logic              d_uses_rs1,
    input  logic              d_uses_rs2,
    input  logic              d_a_pc,
    input  logic              d_b_imm,
    output logic [1:0]        x_asel,
    output logic [1:0]        x_bsel,
    output logic              x_valid,
    output logic              rf_byp1,
    output logic              rf_byp2,
    output logic [CNT_W-1:0]  fwd_cnt,
    output logic [CNT_W-1:0]  kill_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              r_x_valid;
    logic [REG_AW-1:0] r_x_rd;
    logic              r_x_wen;
    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_rd;
    logic              r_wb_wen;
    logic [1:0]        r_x_asel;
    logic [1:0]        r_x_bsel;
    logic              r_x_live;
    logic [CNT_W-1:0]  r_fwd_cnt;
    logic [CNT_W-1:0]  r_kill_cnt;

    logic              w_hit1;
    logic              w_hit2;
    logic              w_byp1;
    logic              w_byp2;
    logic              w_x_fwd;

    // X producer is in WB by the time D reaches X, so it feeds wb_val
    fwd_match #(.REG_AW(REG_AW)) u_hit1 (
        .rec_valid (r_x_valid),
        .rec_rd    (r_x_rd),
        .rec_wen   (r_x_wen),
        .src       (d_rs1),
        .uses      (d_uses_rs1),
        .hit       (w_hit1)
    );

    fwd_match #(.REG_AW(REG_AW)) u_hit2 (
        .rec_valid (r_x_valid),
        .rec_rd    (r_x_rd),
        .rec_wen   (r_x_wen),
        .src       (d_rs2),
        .uses      (d_uses_rs2),
        .hit       (w_hit2)
    );

    // WB producer writes the regfile this cycle; D must read the write data
    fwd_match #(.REG_AW(REG_AW)) u_byp1 (
        .rec_valid (r_wb_valid),
        .rec_rd    (r_wb_rd),
        .rec_wen   (r_wb_wen),
        .src       (d_rs1),
        .uses      (d_uses_rs1),
        .hit       (w_byp1)
    );

    fwd_match #(.REG_AW(REG_AW)) u_byp2 (
        .rec_valid (r_wb_valid),
        .rec_rd    (r_wb_rd),
        .rec_wen   (r_wb_wen),
        .src       (d_rs2),
        .uses      (d_uses_rs2),
        .hit       (w_byp2)
    );

    assign w_x_fwd = r_x_live & (r_x_asel[1] | r_x_bsel[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_valid  <= 1'b0;
            r_x_rd     <= '0;
            r_x_wen    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_wen   <= 1'b0;
            r_x_asel   <= SEL_REG;
            r_x_bsel   <= SEL_REG;
            r_x_live   <= 1'b0;
            r_fwd_cnt  <= '0;
            r_kill_cnt <= '0;
        end else if (!stall) begin
            r_wb_valid <= r_x_valid;
            r_wb_rd    <= r_x_rd;
            r_wb_wen   <= r_x_wen;
            if (w_x_fwd) begin
                r_fwd_cnt <= r_fwd_cnt + CNT_ONE;
            end
            if (flush) begin
                r_x_valid <= 1'b0;
                r_x_rd    <= d_rd;
                r_x_wen   <= d_reg_wen;
                r_x_asel  <= SEL_REG;
                r_x_bsel  <= SEL_REG;
                r_x_live  <= 1'b0;
                if (d_valid) begin
                    r_kill_cnt <= r_kill_cnt + CNT_ONE;
                end
            end else begin
                r_x_valid <= d_valid;
                r_x_rd    <= d_rd;
                r_x_wen   <= d_reg_wen;
                r_x_asel  <= make_sel(w_hit1, d_a_pc);
                r_x_bsel  <= make_sel(w_hit2, d_b_imm);
                r_x_live  <= d_valid;
            end
        end
    end

    assign x_asel   = r_x_asel;
    assign x_bsel   = r_x_bsel;
    assign x_valid  = r_x_live;
    assign rf_byp1  = w_byp1;
    assign rf_byp2  = w_byp2;
    assign fwd_cnt  = r_fwd_cnt;
    assign kill_cnt = r_kill_cnt;

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb/tb_fwd_ctrl.sv - self-checking bench for fwd_ctrl
module tb_fwd_ctrl;

    localparam int AW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          flush;
    logic          d_valid;
    logic [AW-1:0] d_rs1;
    logic [AW-1:0] d_rs2;
    logic [AW-1:0] d_rd;
    logic          d_reg_wen;
    logic          d_uses_rs1;
    logic          d_uses_rs2;
    logic          d_a_pc;
    logic          d_b_imm;
    logic [1:0]    x_asel;
    logic [1:0]    x_bsel;
    logic          x_valid;
    logic          rf_byp1;
    logic          rf_byp2;
    logic [CW-1:0] fwd_cnt;
    logic [CW-1:0] kill_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fwd_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .d_valid    (d_valid),
        .d_rs1      (d_rs1),
        .d_rs2      (d_rs2),
        .d_rd       (d_rd),
        .d_reg_wen  (d_reg_wen),
        .d_uses_rs1 (d_uses_rs1),
        .d_uses_rs2 (d_uses_rs2),
        .d_a_pc     (d_a_pc),
        .d_b_imm    (d_b_imm),
        .x_asel     (x_asel),
        .x_bsel     (x_bsel),
        .x_valid    (x_valid),
        .rf_byp1    (rf_byp1),
        .rf_byp2    (rf_byp2),
        .fwd_cnt    (fwd_cnt),
        .kill_cnt   (kill_cnt)
    );

    // Reference: the instruction occupying each stage, with the selects it was issued with
    typedef struct {
        bit       live;
        int       rd;
        bit       wen;
        bit [1:0] asel;
        bit [1:0] bsel;
    } slot_t;

    slot_t       m_x;
    slot_t       m_wb;
    int unsigned m_fwd;
    int unsigned m_kill;

    function automatic bit produces(slot_t p, bit uses, int rs);
        return uses && (rs != 0) && p.live && p.wen && (p.rd == rs);
    endfunction

    task automatic model_clear();
        m_x    = '{live: 0, rd: 0, wen: 0, asel: 2'b00, bsel: 2'b00};
        m_wb   = m_x;
        m_fwd  = 0;
        m_kill = 0;
    endtask

    task automatic set_d(input bit v, input int rs1, input int rs2, input int rd, input bit wen,
                         input bit u1, input bit u2, input bit apc, input bit bimm);
        d_valid    = v;
        d_rs1      = AW'(rs1);
        d_rs2      = AW'(rs2);
        d_rd       = AW'(rd);
        d_reg_wen  = wen;
        d_uses_rs1 = u1;
        d_uses_rs2 = u2;
        d_a_pc     = apc;
        d_b_imm    = bimm;
    endtask

    task automatic set_idle();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        slot_t nx;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else if (!stall) begin
            if (m_x.live && (m_x.asel[1] || m_x.bsel[1])) m_fwd++;
            if (flush) begin
                nx = '{live: 0, rd: 0, wen: 0, asel: 2'b00, bsel: 2'b00};
                if (d_valid) m_kill++;
            end else begin
                nx.live = d_valid;
                nx.rd   = int'(d_rd);
                nx.wen  = d_reg_wen;
                nx.asel = {produces(m_x, d_uses_rs1, int'(d_rs1)), d_a_pc};
                nx.bsel = {produces(m_x, d_uses_rs2, int'(d_rs2)), d_b_imm};
            end
            m_wb = m_x;
            m_x  = nx;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        stall = 0;
        flush = 0;
        set_idle();
        rst_n = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({x_asel, x_bsel, x_valid, rf_byp1, rf_byp2} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b want 0000000", {x_asel, x_bsel, x_valid, rf_byp1, rf_byp2});
        end
        n_checks++;
        if (fwd_cnt !== 0 || kill_cnt !== 0) begin
            n_errors++;
            $display("FAIL reset_counters: got fwd=%0d kill=%0d want 0 0", fwd_cnt, kill_cnt);
        end
        rst_n = 1;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if ({x_valid, x_asel, x_bsel} !== 5'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: got %b want 00000", {x_valid, x_asel, x_bsel});
        end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] f0;
        f0 = fwd_cnt;
        set_d(1, 1, 2, 5, 1, 1, 1, 0, 0);
        tick();
        set_d(1, 5, 1, 6, 1, 1, 1, 0, 0);
        tick();
        n_checks++;
        if (x_asel !== 2'b10 || x_bsel !== 2'b00 || x_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_sel: got asel=%b bsel=%b v=%b want 10 00 1", x_asel, x_bsel, x_valid);
        end
        set_idle();
        tick();
        n_checks++;
        if (fwd_cnt !== f0 + 1) begin
            n_errors++;
            $display("FAIL b2b_fwd_cnt: got %0d want %0d", fwd_cnt, f0 + 1);
        end
    endtask

    task automatic test_alt_fwd();
        set_d(1, 1, 2, 7, 1, 1, 1, 0, 0);
        tick();
        set_d(1, 7, 7, 8, 1, 1, 1, 1, 1);
        tick();
        n_checks++;
        if (x_asel !== 2'b11 || x_bsel !== 2'b11) begin
            n_errors++;
            $display("FAIL alt_fwd: got asel=%b bsel=%b want 11 11", x_asel, x_bsel);
        end
        set_idle();
        tick();
    endtask

    task automatic test_dist2_x0();
        set_d(1, 1, 2, 3, 1, 1, 1, 0, 0);
        tick();
        set_idle();
        tick();
        set_d(1, 3, 4, 10, 1, 1, 1, 0, 0);
        #1;
        n_checks++;
        if (rf_byp1 !== 1'b1 || rf_byp2 !== 1'b0) begin
            n_errors++;
            $display("FAIL dist2_byp: got byp1=%b byp2=%b want 1 0", rf_byp1, rf_byp2);
        end
        tick();
        n_checks++;
        if (x_asel !== 2'b00) begin
            n_errors++;
            $display("FAIL dist2_asel: got %b want 00", x_asel);
        end
        set_d(1, 1, 2, 0, 1, 1, 1, 0, 0);
        tick();
        set_d(1, 0, 0, 11, 1, 1, 1, 0, 0);
        tick();
        n_checks++;
        if (x_asel !== 2'b00 || x_bsel !== 2'b00) begin
            n_errors++;
            $display("FAIL x0_nofwd: got asel=%b bsel=%b want 00 00", x_asel, x_bsel);
        end
        set_d(1, 0, 0, 12, 1, 1, 1, 0, 0);
        #1;
        n_checks++;
        if (rf_byp1 !== 1'b0 || rf_byp2 !== 1'b0) begin
            n_errors++;
            $display("FAIL x0_nobyp: got byp1=%b byp2=%b want 0 0", rf_byp1, rf_byp2);
        end
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_flush();
        logic [CW-1:0] k0;
        k0 = kill_cnt;
        set_d(1, 1, 2, 9, 1, 1, 1, 1, 1);
        flush = 1;
        tick();
        flush = 0;
        n_checks++;
        if (x_valid !== 1'b0 || x_asel !== 2'b00 || x_bsel !== 2'b00 || kill_cnt !== k0 + 1) begin
            n_errors++;
            $display("FAIL flush_kill: got v=%b asel=%b bsel=%b kill=%0d want 0 00 00 %0d",
                     x_valid, x_asel, x_bsel, kill_cnt, k0 + 1);
        end
        set_d(1, 9, 9, 14, 1, 1, 1, 0, 0);
        tick();
        n_checks++;
        if (x_asel !== 2'b00 || x_bsel !== 2'b00) begin
            n_errors++;
            $display("FAIL flush_no_fwd: got asel=%b bsel=%b want 00 00", x_asel, x_bsel);
        end
        set_d(1, 9, 1, 15, 1, 1, 1, 0, 0);
        #1;
        n_checks++;
        if (rf_byp1 !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_no_byp: got %b want 0", rf_byp1);
        end
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_stall_reset();
        logic [CW+CW+4:0] snap;
        set_d(1, 1, 2, 12, 1, 1, 1, 1, 1);
        tick();
        set_d(1, 12, 12, 13, 1, 1, 1, 1, 0);
        stall = 1;
        flush = 1;
        snap  = {x_asel, x_bsel, x_valid, fwd_cnt, kill_cnt};
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({x_asel, x_bsel, x_valid, fwd_cnt, kill_cnt} !== snap) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i,
                         {x_asel, x_bsel, x_valid, fwd_cnt, kill_cnt}, snap);
            end
        end
        n_checks++;
        if (x_asel !== 2'b01 || x_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_state: got asel=%b v=%b want 01 1", x_asel, x_valid);
        end
        #2;
        rst_n = 0;
        model_clear();
        #1;
        n_checks++;
        if ({x_asel, x_bsel, x_valid, rf_byp1, rf_byp2} !== 7'b0 || fwd_cnt !== 0 || kill_cnt !== 0) begin
            n_errors++;
            $display("FAIL async_reset: got sel=%b%b v=%b byp=%b%b fwd=%0d kill=%0d want all 0",
                     x_asel, x_bsel, x_valid, rf_byp1, rf_byp2, fwd_cnt, kill_cnt);
        end
        tick();
        rst_n = 1;
        stall = 0;
        flush = 0;
        set_idle();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 9) < 2);
            flush = ($urandom_range(0, 9) < 2);
            set_d($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            #1;
            n_checks++;
            if (rf_byp1 !== produces(m_wb, d_uses_rs1, int'(d_rs1)) ||
                rf_byp2 !== produces(m_wb, d_uses_rs2, int'(d_rs2))) begin
                n_errors++;
                $display("FAIL rand_byp[%0d]: got %b%b want %b%b", i, rf_byp1, rf_byp2,
                         produces(m_wb, d_uses_rs1, int'(d_rs1)), produces(m_wb, d_uses_rs2, int'(d_rs2)));
            end
            tick();
            n_checks++;
            if (x_asel !== m_x.asel || x_bsel !== m_x.bsel || x_valid !== m_x.live ||
                fwd_cnt !== m_fwd || kill_cnt !== m_kill) begin
                n_errors++;
                $display("FAIL rand_x[%0d]: got asel=%b bsel=%b v=%b fwd=%0d kill=%0d want %b %b %b %0d %0d",
                         i, x_asel, x_bsel, x_valid, fwd_cnt, kill_cnt,
                         m_x.asel, m_x.bsel, m_x.live, m_fwd, m_kill);
            end
        end
        stall = 0;
        flush = 0;
        set_idle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_alt_fwd();
        test_dist2_x0();
        test_flush();
        test_stall_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
